// File: rtl/cmd_encoder_pkg.sv
// Package cmd_pkg: shared codes for the stopwatch command front end.
//   Command codes (cmd port) : CMD_NOP, CMD_START, CMD_PAUSE, CMD_STOP
//   Run-state codes (run_st) : RS_STOPPED, RS_RUNNING, RS_PAUSED
//   run_next()               : run-state transition for a registered command
package cmd_pkg;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_PAUSE = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  localparam logic [1:0] RS_STOPPED = 2'd0;
  localparam logic [1:0] RS_RUNNING = 2'd1;
  localparam logic [1:0] RS_PAUSED  = 2'd2;

  // Mirrors the consumer FSM: pause is accepted from STOPPED too, nop holds.
  function automatic logic [1:0] run_next(input logic [1:0] rs, input logic [1:0] c);
    logic [1:0] nx;
    nx = rs;
    case (c)
      CMD_START: nx = RS_RUNNING;
      CMD_PAUSE: nx = RS_PAUSED;
      CMD_STOP:  nx = RS_STOPPED;
      default:   nx = rs;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/cmd_encoder_btn_debounce.sv
// btn_debounce: one push-button channel.
//   2-flop synchronizer, counter-based debounce, rising-edge press detect.
// Ports:
//   clk   in  system clock
//   clr   in  asynchronous active-high reset
//   raw   in  raw asynchronous button level
//   level out debounced level
//   press out one-cycle pulse on a debounced rising edge
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing synchronized samples needed to accept a change (>=2)
//   CNT_W            counter width, derived
module btn_debounce #(
  parameter  int unsigned DEBOUNCE_CYCLES = 16,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      // Any sample agreeing with the accepted level restarts the count.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = stable;
  assign press = stable & ~stable_q;

endmodule

// File: rtl/cmd_encoder.sv
// cmd_encoder: stopwatch command front end. Debounces three raw buttons and
// emits one-cycle 2-bit command pulses (idle = nop) for the control FSM.
// Ports:
//   clk        in  system clock, posedge
//   clr        in  asynchronous active-high reset
//   btn_start  in  raw start button
//   btn_pause  in  raw pause button
//   btn_stop   in  raw stop button
//   cmd        out registered command (0 nop, 1 start, 2 pause, 3 stop)
//   run_st     out registered mirror of consumer state (0 STOPPED, 1 RUNNING, 2 PAUSED)
// Configuration:
//   CMD_TOGGLE_EN  btn_start toggles start/pause based on run_st; btn_pause masked.
module cmd_encoder
  import cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_stop,
  output logic [1:0] cmd,
  output logic [1:0] run_st
);

  logic start_lvl, pause_lvl, stop_lvl;
  logic start_p, pause_p, stop_p;
  logic [1:0] cmd_next;
  logic unused_sigs;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(clk), .clr(clr), .raw(btn_start), .level(start_lvl), .press(start_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .clk(clk), .clr(clr), .raw(btn_pause), .level(pause_lvl), .press(pause_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
    .clk(clk), .clr(clr), .raw(btn_stop), .level(stop_lvl), .press(stop_p)
  );

  // Simultaneous presses: stop > pause > start; losers are dropped.
  always_comb begin
    cmd_next = CMD_NOP;
    if (stop_p) begin
      cmd_next = CMD_STOP;
`ifdef CMD_TOGGLE_EN
    end else if (start_p) begin
      cmd_next = (run_st == RS_RUNNING) ? CMD_PAUSE : CMD_START;
`else
    end else if (pause_p) begin
      cmd_next = CMD_PAUSE;
    end else if (start_p) begin
      cmd_next = CMD_START;
`endif
    end
  end

`ifdef CMD_TOGGLE_EN
  assign unused_sigs = ^{start_lvl, pause_lvl, stop_lvl, pause_p};
`else
  assign unused_sigs = ^{start_lvl, pause_lvl, stop_lvl};
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cmd    <= CMD_NOP;
      run_st <= RS_STOPPED;
    end else begin
      cmd    <= cmd_next;
      run_st <= run_next(run_st, cmd_next);
    end
  end

endmodule

// File: tb/tb_cmd_encoder.sv
module tb_cmd_encoder;
  import cmd_pkg::*;

  localparam int D   = 4;
  localparam int LAT = D + 2;  // sample edge -> edge that registers cmd

  logic       clk = 1'b0;
  logic       clr;
  logic       btn_start, btn_pause, btn_stop;
  logic [1:0] cmd, run_st;

  cmd_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .clr(clr), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_stop(btn_stop), .cmd(cmd), .run_st(run_st)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct {
    int         cyc;
    logic [1:0] c;
    logic [1:0] rs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;
  bit   done_chk = 1'b0;

  // Monitor: every non-nop cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (clr) begin
      n_cmp++;
      if (cmd !== CMD_NOP || run_st !== RS_STOPPED) begin
        n_bad++;
        $display("FAIL reset_state: edge=%0d got cmd=%0d run_st=%0d, required cmd=0 run_st=0",
                 edge_n, cmd, run_st);
      end
    end else if (cmd !== CMD_NOP) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_cmd: edge=%0d got cmd=%0d run_st=%0d, required cmd=0",
                 edge_n, cmd, run_st);
      end else begin
        e = sb.pop_front();
        if (edge_n != e.cyc || cmd !== e.c || run_st !== e.rs) begin
          n_bad++;
          $display("FAIL cmd_pulse: got edge=%0d cmd=%0d run_st=%0d, required edge=%0d cmd=%0d run_st=%0d",
                   edge_n, cmd, run_st, e.cyc, e.c, e.rs);
        end
      end
    end
    if (done && !done_chk) begin
      done_chk = 1'b1;
      n_cmp++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL missing_cmd: %0d outstanding, next required edge=%0d cmd=%0d, got none",
                 sb.size(), sb[0].cyc, sb[0].c);
      end
    end
  end

  // Called at a negedge; buttons b = {stop, pause, start} are sampled on the next edge.
  task automatic press(input logic [2:0] b, input int hold, input bit exp,
                       input logic [1:0] ec, input logic [1:0] ers);
    {btn_stop, btn_pause, btn_start} = b;
    if (exp) sb.push_back('{edge_n + 1 + LAT, ec, ers});
    repeat (hold) @(negedge clk);
    {btn_stop, btn_pause, btn_start} = 3'b000;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    clr = 1'b1;
    {btn_stop, btn_pause, btn_start} = 3'b000;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    while (edge_n < 9) @(negedge clk);

    // Clean start press sampled at edge 10 -> cmd in cycle after edge 16.
    press(3'b001, 20, 1'b1, CMD_START, RS_RUNNING);

    // Pause bounce: no command until steady, then full latency from steady.
    btn_pause = 1'b1; @(negedge clk);
    btn_pause = 1'b0; @(negedge clk);
    btn_pause = 1'b1; @(negedge clk);
    btn_pause = 1'b0; @(negedge clk);
`ifdef CMD_TOGGLE_EN
    press(3'b010, 20, 1'b0, CMD_NOP, RS_RUNNING);
`else
    press(3'b010, 20, 1'b1, CMD_PAUSE, RS_PAUSED);
`endif

    // Stop and start together: stop wins, start is dropped.
    press(3'b101, 20, 1'b1, CMD_STOP, RS_STOPPED);

    // Reset mid-debounce (cnt=2) with start held.
    btn_start = 1'b1;
    repeat (4) @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    press(3'b001, 20, 1'b1, CMD_START, RS_RUNNING);

`ifdef CMD_TOGGLE_EN
    press(3'b010, 20, 1'b0, CMD_NOP,   RS_RUNNING);
    press(3'b001, 20, 1'b1, CMD_PAUSE, RS_PAUSED);
    press(3'b001, 20, 1'b1, CMD_START, RS_RUNNING);
    press(3'b001, 100, 1'b1, CMD_PAUSE, RS_PAUSED);
`else
    press(3'b010, 20, 1'b1, CMD_PAUSE, RS_PAUSED);
    press(3'b001, 20, 1'b1, CMD_START, RS_RUNNING);
    press(3'b100, 20, 1'b1, CMD_STOP,  RS_STOPPED);
    press(3'b001, 100, 1'b1, CMD_START, RS_RUNNING);
`endif

    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
